mmio_timer: RTL
===============

# mmio_timer

Memory-mapped 64-bit machine timer on the CPU data memory bus. It decodes its own 32-byte window, serves reads with the same one-cycle synchronous latency as data BRAM, and drives the CPU `interrupt_i` line when `mtime >= mtimecmp`. The system-level read mux selects `read_data_o` using `hit_o`.

## Interface
- `BASE_ADDR`, default `32'hFF00_0000`: window base. Must be 32-byte aligned; bits [4:0] are ignored.
- `clk_i` in, 1: system clock.
- `rst_ni` in, 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `addr_i` in, 32 (`word_t`): dmem address from the CPU.
- `write_data_i` in, 32 (`word_t`): dmem write data.
- `write_mask_i` in, 4: byte write enables. A value of 0 means no write.
- `read_data_o` out, 32 (`word_t`): registered read data.
- `hit_o` out, 1: registered. Set when last cycle's address was in the window.
- `interrupt_o` out, 1: registered timer interrupt, connected to CPU `interrupt_i`.

## Operation
- Window hit: `addr_i[31:5] == BASE_ADDR[31:5]`. Register index is `addr_i[4:2]`. `addr_i[1:0]` is ignored.
- Register map (offset):
  - 0x00 MTIME_LO
  - 0x04 MTIME_HI
  - 0x08 MTIMECMP_LO
  - 0x0C MTIMECMP_HI
  - 0x10 CTRL: bit0 EN (count enable), bit1 IE (interrupt enable), [31:16] PRESCALE. All other bits read 0.
  - 0x14 STATUS: read-only. bit0 = `mtime >= mtimecmp`, unsigned 64-bit compare. Other bits read 0.
  - 0x18 and 0x1C: read 0, writes ignored.
- Writes: applied per byte lane on the clock edge when hit and `write_mask_i != 0`. Writes to STATUS are ignored.
- Prescaler: a 16-bit counter `pre_q`.
  - When EN=1: if `pre_q == PRESCALE`, the cycle is a tick and `pre_q` returns to 0; otherwise `pre_q` increments.
  - PRESCALE=0 gives a tick every cycle.
  - EN=0 holds both `pre_q` and `mtime`.
  - Any CTRL write clears `pre_q` to 0.
- On a tick, `mtime` increments by 1 (64-bit). `2^64-1` wraps to 0.
- A software write to MTIME_LO or MTIME_HI in the same cycle as a tick takes priority:
  - The written bytes take the written values.
  - Unwritten bytes of that 32-bit half hold.
  - The other half holds; no carry propagates that cycle.
- HI shadow: a hit to MTIME_LO with `write_mask_i == 0` latches the current `mtime[63:32]` into `shadow_q`. Reads of MTIME_HI return `shadow_q`, so a LO-then-HI read pair is coherent.
- Read data: each cycle, `read_data_o <=` the selected register if hit, else 0. Reads have no side effects other than the shadow latch.
- Interrupt: `interrupt_o <= IE & (mtime >= mtimecmp)`, computed from current register values.
- Reset values:
  - `mtime` = 0
  - `mtimecmp` = `64'hFFFF_FFFF_FFFF_FFFF`
  - CTRL = 0, `pre_q` = 0, `shadow_q` = 0
  - `read_data_o` = 0, `hit_o` = 0, `interrupt_o` = 0
- Reset asserted mid-count or mid-access forces all of the above immediately. The first edge after deassertion behaves as a normal cycle.

## Timing
- Read latency is 1 cycle: for an address presented in cycle N, `read_data_o` and `hit_o` are valid in cycle N+1. This matches the CPU MA to WB dmem timing.
- Read and write to the same register in the same cycle: the read returns the old value.
- A write in cycle N is visible to a read addressed in cycle N+1, with data in N+2.
- A tick at edge k updates `mtime` at edge k. STATUS reflects it for reads addressed after edge k.
- `interrupt_o` reflects the compare one edge after the operand change:
  - `mtime` reaches `mtimecmp` at edge k, so `interrupt_o` rises at edge k+1.
  - Writing `mtimecmp` above `mtime` at edge k drops `interrupt_o` at edge k+1.
- No handshake or stall: every access completes in one cycle.

## Structure
- Add to package `common`:
  - `timer_reg_t`: 3-bit enum of register indices.
  - Constants `TIMER_CTRL_EN_BIT = 0`, `TIMER_CTRL_IE_BIT = 1`, `TIMER_PRESCALE_LSB = 16`.
  - `TIMER_BASE_ADDR`.
- One natural sub-module: `timer_prescaler`. Inputs: `clk_i`, `rst_ni`, `en_i`, `clear_i`, `reload_i[15:0]`. Output: `tick_o`.
- Everything else is inline in `mmio_timer`.

## Test plan
- Reset, then read all eight offsets: MTIMECMP_LO and MTIMECMP_HI return `32'hFFFF_FFFF`, all others 0, and `interrupt_o` = 0.
- CTRL=`0x0000_0001`, then wait 10 cycles and read MTIME_LO: value 9–11, exact per testbench cycle count; `hit_o` = 1 one cycle after the address.
- CTRL=`0x0003_0001` (PRESCALE=3): `mtime` increments exactly every 4 cycles. A CTRL rewrite mid-period restarts the 4-cycle spacing from the write.
- MTIME = `0x0000_0000_FFFF_FFFE` with EN=1: after the carry, a LO read returns `0x0000_0000` and the following HI read returns `0x0000_0001`. Write MTIME_HI = `0xFFFF_FFFF` and LO = `0xFFFF_FFFF`: `mtime` wraps to 0.
- MTIMECMP = 20, CTRL=`0x3`: `interrupt_o` rises exactly one cycle after `mtime` reaches 20. Writing MTIMECMP_LO = 1000 drops it one cycle after the write. With IE=0, STATUS bit0 = 1 but `interrupt_o` = 0.
- Byte-masked write of mask `4'b0100` to MTIMECMP_LO changes only bits [23:16]. Access to `BASE_ADDR+0x20` gives `hit_o` = 0, `read_data_o` = 0, and no register change. Asserting `rst_ni` low mid-count zeroes `mtime` without waiting for a clock edge.

Source files
------------

// File: rtl/common_pkg.sv
// Shared types and constants for the machine-timer MMIO slice.
package common;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    TIMER_MTIME_LO    = 3'd0,
    TIMER_MTIME_HI    = 3'd1,
    TIMER_MTIMECMP_LO = 3'd2,
    TIMER_MTIMECMP_HI = 3'd3,
    TIMER_CTRL        = 3'd4,
    TIMER_STATUS      = 3'd5,
    TIMER_RSVD6       = 3'd6,
    TIMER_RSVD7       = 3'd7
  } timer_reg_t;

  localparam int TIMER_CTRL_EN_BIT  = 0;
  localparam int TIMER_CTRL_IE_BIT  = 1;
  localparam int TIMER_PRESCALE_LSB = 16;

  localparam word_t TIMER_BASE_ADDR = 32'hFF00_0000;
  // Only EN, IE and PRESCALE are stored; everything else in CTRL reads back 0.
  localparam word_t TIMER_CTRL_MASK = 32'hFFFF_0003;

  function automatic word_t apply_byte_mask(word_t old_val, word_t new_val,
                                            logic [3:0] mask);
    word_t res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for mtime: one tick every reload_i+1 enabled cycles, restartable by clear_i.
module timer_prescaler (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        clear_i,
  input  logic [15:0] reload_i,
  output logic        tick_o
);

  logic [15:0] pre_d, pre_q;

  assign tick_o = en_i && (pre_q == reload_i);

  always_comb begin
    pre_d = pre_q;
    if (clear_i) begin
      pre_d = '0;
    end else if (en_i) begin
      pre_d = tick_o ? 16'd0 : pre_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped 64-bit machine timer: 32-byte register window, one-cycle
// registered reads, and a registered mtime >= mtimecmp interrupt.
module mmio_timer
  import common::*;
#(
  parameter word_t BASE_ADDR = TIMER_BASE_ADDR
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  word_t      addr_i,
  input  word_t      write_data_i,
  input  logic [3:0] write_mask_i,
  output word_t      read_data_o,
  output logic       hit_o,
  output logic       interrupt_o
);

  logic        win_hit, wr_en, ctrl_wr, mtime_wr, tick, mtime_ge;
  logic        unused_addr;
  timer_reg_t  reg_idx;
  logic [63:0] mtime_d, mtime_q;
  logic [63:0] mtimecmp_d, mtimecmp_q;
  word_t       ctrl_d, ctrl_q;
  word_t       shadow_d, shadow_q;
  word_t       rdata_d, rdata_q;
  logic        hit_d, hit_q;
  logic        irq_d, irq_q;

  assign win_hit     = (addr_i[31:5] == BASE_ADDR[31:5]);
  assign reg_idx     = timer_reg_t'(addr_i[4:2]);
  assign wr_en       = win_hit && (write_mask_i != 4'b0000);
  assign ctrl_wr     = wr_en && (reg_idx == TIMER_CTRL);
  assign mtime_wr    = wr_en && ((reg_idx == TIMER_MTIME_LO) || (reg_idx == TIMER_MTIME_HI));
  assign mtime_ge    = (mtime_q >= mtimecmp_q);
  assign unused_addr = ^addr_i[1:0];

  timer_prescaler u_prescaler (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (ctrl_q[TIMER_CTRL_EN_BIT]),
    .clear_i  (ctrl_wr),
    .reload_i (ctrl_q[TIMER_PRESCALE_LSB +: 16]),
    .tick_o   (tick)
  );

  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    ctrl_d     = ctrl_q;
    shadow_d   = shadow_q;
    rdata_d    = '0;
    hit_d      = win_hit;
    irq_d      = ctrl_q[TIMER_CTRL_IE_BIT] && mtime_ge;

    // A software write to either mtime half wins over a tick; no carry that cycle.
    if (wr_en) begin
      case (reg_idx)
        TIMER_MTIME_LO:
          mtime_d[31:0] = apply_byte_mask(mtime_q[31:0], write_data_i, write_mask_i);
        TIMER_MTIME_HI:
          mtime_d[63:32] = apply_byte_mask(mtime_q[63:32], write_data_i, write_mask_i);
        TIMER_MTIMECMP_LO:
          mtimecmp_d[31:0] = apply_byte_mask(mtimecmp_q[31:0], write_data_i, write_mask_i);
        TIMER_MTIMECMP_HI:
          mtimecmp_d[63:32] = apply_byte_mask(mtimecmp_q[63:32], write_data_i, write_mask_i);
        TIMER_CTRL:
          ctrl_d = apply_byte_mask(ctrl_q, write_data_i, write_mask_i) & TIMER_CTRL_MASK;
        default: ;
      endcase
    end

    if (tick && !mtime_wr) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (win_hit && (write_mask_i == 4'b0000) && (reg_idx == TIMER_MTIME_LO)) begin
      shadow_d = mtime_q[63:32];
    end

    if (win_hit) begin
      case (reg_idx)
        TIMER_MTIME_LO:    rdata_d = mtime_q[31:0];
        TIMER_MTIME_HI:    rdata_d = shadow_q;
        TIMER_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
        TIMER_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
        TIMER_CTRL:        rdata_d = ctrl_q;
        TIMER_STATUS:      rdata_d = {31'b0, mtime_ge};
        default:           rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      ctrl_q     <= '0;
      shadow_q   <= '0;
      rdata_q    <= '0;
      hit_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      ctrl_q     <= ctrl_d;
      shadow_q   <= shadow_d;
      rdata_q    <= rdata_d;
      hit_q      <= hit_d;
      irq_q      <= irq_d;
    end
  end

  assign read_data_o = rdata_q;
  assign hit_o       = hit_q;
  assign interrupt_o = irq_q;

endmodule
